pipelined_data_path: RTL and testbench

- Three-stage pipelined successor of the single-cycle 16-bit datapath: register read (RD), execute/memory (EX), writeback (WB).
- Contains a parametrised register file, an ALU, a synchronous data RAM and the writeback select.
- Accepts one control word per cycle through a valid/ready handshake, with full operand forwarding and a one-cycle load-use stall.
- Sits between the instruction decoder/controller and the ALU/debug observation outputs.

---
 rtl/dp_pkg.sv | 35 +++
 rtl/dp_register_file.sv | 35 +++
 rtl/pipelined_data_path.sv | 171 +++++++++++++++++
 tb/tb_pipelined_data_path.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared ALU opcodes and pipeline control words for pipelined_data_path
package dp_pkg;

    localparam int ALU_SEL_W = 4;

    typedef enum logic [ALU_SEL_W-1:0] {
        ZERO   = 4'd0,
        ADD    = 4'd1,
        SUB    = 4'd2,
        AND    = 4'd3,
        OR     = 4'd4,
        XOR    = 4'd5,
        NOT_A  = 4'd6,
        PASS_A = 4'd7,
        PASS_B = 4'd8,
        SHL    = 4'd9,
        SHR    = 4'd10,
        INC    = 4'd11,
        DEC    = 4'd12
    } alu_op_e;

    // Register addresses are carried beside these words so their widths follow the top parameters.
    typedef struct packed {
        logic    d_wr;
        logic    rf_s;
        logic    rf_w_en;
        alu_op_e alu_sel;
    } ex_ctl_t;

    typedef struct packed {
        logic rf_s;
        logic rf_w_en;
    } wb_ctl_t;

endpackage

// File: rtl/dp_register_file.sv
// rtl/dp_register_file.sv - register array, two combinational reads, one synchronous write
module dp_register_file #(
    parameter int WIDTH    = 16,
    parameter int R_ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [R_ADDR_W-1:0] a_addr,
    input  logic [R_ADDR_W-1:0] b_addr,
    output logic [WIDTH-1:0]    a_data,
    output logic [WIDTH-1:0]    b_data,
    input  logic                w_en,
    input  logic [R_ADDR_W-1:0] w_addr,
    input  logic [WIDTH-1:0]    w_data
);

    localparam int DEPTH = 2 ** R_ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];

    // No read-during-write bypass here; the pipeline forwards from WB itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (w_en) begin
            regs[w_addr] <= w_data;
        end
    end

    assign a_data = regs[a_addr];
    assign b_data = regs[b_addr];

endmodule

// File: rtl/pipelined_data_path.sv
// rtl/pipelined_data_path.sv - three-stage RD/EX/WB datapath with forwarding and load-use stall
module pipelined_data_path
    import dp_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int D_ADDR_W = 8,
    parameter int R_ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [D_ADDR_W-1:0]  D_addr,
    input  logic [R_ADDR_W-1:0]  RF_W_addr,
    input  logic [R_ADDR_W-1:0]  RF_A_addr,
    input  logic [R_ADDR_W-1:0]  RF_B_addr,
    input  logic                 D_wr,
    input  logic                 RF_s,
    input  logic                 RF_W_en,
    input  logic [ALU_SEL_W-1:0] ALU_sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     ALU_A,
    output logic [WIDTH-1:0]     ALU_B,
    output logic [WIDTH-1:0]     ALU_Out,
    output logic [WIDTH-1:0]     wb_data
);

    localparam int D_DEPTH = 2 ** D_ADDR_W;

    logic [WIDTH-1:0]    rf_a_data, rf_b_data;
    logic [WIDTH-1:0]    fwd_a, fwd_b;
    logic                stall, accept;

    logic                ex_valid;
    ex_ctl_t             ex_ctl;
    logic [D_ADDR_W-1:0] ex_d_addr;
    logic [R_ADDR_W-1:0] ex_w_addr;
    logic [WIDTH-1:0]    ex_a, ex_b;
    logic [WIDTH-1:0]    alu_result;
    logic                ex_fwd_ok;

    logic                wb_valid;
    wb_ctl_t             wb_ctl;
    logic [R_ADDR_W-1:0] wb_w_addr;
    logic [WIDTH-1:0]    wb_a, wb_b, wb_alu, wb_q;
    logic                wb_fwd_ok;

    logic [WIDTH-1:0]    mem [D_DEPTH];

    dp_register_file #(
        .WIDTH    (WIDTH),
        .R_ADDR_W (R_ADDR_W)
    ) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_addr (RF_A_addr),
        .b_addr (RF_B_addr),
        .a_data (rf_a_data),
        .b_data (rf_b_data),
        .w_en   (wb_valid && wb_ctl.rf_w_en),
        .w_addr (wb_w_addr),
        .w_data (wb_data)
    );

    // A load in EX has no data until WB, so any operand match holds the presented word one cycle.
    assign stall    = ex_valid && ex_ctl.rf_w_en && !ex_ctl.rf_s &&
                      ((ex_w_addr == RF_A_addr) || (ex_w_addr == RF_B_addr));
    assign in_ready = !stall;
    assign accept   = in_valid && !stall;

    assign ex_fwd_ok = ex_valid && ex_ctl.rf_w_en && ex_ctl.rf_s;
    assign wb_fwd_ok = wb_valid && wb_ctl.rf_w_en;

    always_comb begin
        fwd_a = rf_a_data;
        if (ex_fwd_ok && (ex_w_addr == RF_A_addr)) begin
            fwd_a = alu_result;
        end else if (wb_fwd_ok && (wb_w_addr == RF_A_addr)) begin
            fwd_a = wb_data;
        end
    end

    always_comb begin
        fwd_b = rf_b_data;
        if (ex_fwd_ok && (ex_w_addr == RF_B_addr)) begin
            fwd_b = alu_result;
        end else if (wb_fwd_ok && (wb_w_addr == RF_B_addr)) begin
            fwd_b = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_ctl    <= '0;
            ex_d_addr <= '0;
            ex_w_addr <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
        end else begin
            ex_valid <= accept;
            if (accept) begin
                ex_ctl.d_wr    <= D_wr;
                ex_ctl.rf_s    <= RF_s;
                ex_ctl.rf_w_en <= RF_W_en;
                ex_ctl.alu_sel <= alu_op_e'(ALU_sel);
                ex_d_addr      <= D_addr;
                ex_w_addr      <= RF_W_addr;
                ex_a           <= fwd_a;
                ex_b           <= fwd_b;
            end
        end
    end

    always_comb begin
        alu_result = '0;
        case (ex_ctl.alu_sel)
            ZERO:    alu_result = '0;
            ADD:     alu_result = ex_a + ex_b;
            SUB:     alu_result = ex_a - ex_b;
            AND:     alu_result = ex_a & ex_b;
            OR:      alu_result = ex_a | ex_b;
            XOR:     alu_result = ex_a ^ ex_b;
            NOT_A:   alu_result = ~ex_a;
            PASS_A:  alu_result = ex_a;
            PASS_B:  alu_result = ex_b;
            SHL:     alu_result = {ex_a[WIDTH-2:0], 1'b0};
            SHR:     alu_result = {1'b0, ex_a[WIDTH-1:1]};
            INC:     alu_result = ex_a + WIDTH'(1);
            DEC:     alu_result = ex_a - WIDTH'(1);
            default: alu_result = '0;
        endcase
    end

    // RAM contents survive reset; ex_valid drops at once so a held store never lands.
    always_ff @(posedge clk) begin
        if (ex_valid && ex_ctl.d_wr) begin
            mem[ex_d_addr] <= ex_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid  <= 1'b0;
            wb_ctl    <= '0;
            wb_w_addr <= '0;
            wb_a      <= '0;
            wb_b      <= '0;
            wb_alu    <= '0;
            wb_q      <= '0;
        end else begin
            wb_valid <= ex_valid;
            if (ex_valid) begin
                wb_ctl.rf_s    <= ex_ctl.rf_s;
                wb_ctl.rf_w_en <= ex_ctl.rf_w_en;
                wb_w_addr      <= ex_w_addr;
                wb_a           <= ex_a;
                wb_b           <= ex_b;
                wb_alu         <= alu_result;
                wb_q           <= ex_ctl.d_wr ? ex_a : mem[ex_d_addr];
            end
        end
    end

    assign out_valid = wb_valid;
    assign ALU_A     = wb_a;
    assign ALU_B     = wb_b;
    assign ALU_Out   = wb_alu;
    assign wb_data   = wb_ctl.rf_s ? wb_alu : wb_q;

endmodule

// File: tb/tb_pipelined_data_path.sv
// tb/tb_pipelined_data_path.sv - randomized and directed checks against an in-order architectural model
module tb_pipelined_data_path;
    import dp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  D_addr = '0;
    logic [3:0]  RF_W_addr = '0, RF_A_addr = '0, RF_B_addr = '0;
    logic        D_wr = 1'b0, RF_s = 1'b0, RF_W_en = 1'b0;
    logic [3:0]  ALU_sel = '0;
    logic        out_valid;
    logic [15:0] ALU_A, ALU_B, ALU_Out, wb_data;

    pipelined_data_path dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .D_addr(D_addr), .RF_W_addr(RF_W_addr), .RF_A_addr(RF_A_addr), .RF_B_addr(RF_B_addr),
        .D_wr(D_wr), .RF_s(RF_s), .RF_W_en(RF_W_en), .ALU_sel(ALU_sel),
        .out_valid(out_valid), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Out(ALU_Out), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] a, b, alu, wb;
    } exp_t;

    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    logic        acc = 1'b0;
    logic        m_ex_load = 1'b0;
    logic [3:0]  m_ex_w = '0;
    logic [15:0] m_regs [16];
    logic [15:0] m_mem [256];
    exp_t        expq [$];
    logic [15:0] last_a = '0, last_b = '0, last_alu = '0, last_wb = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_alu(input int sel, input int a, input int b);
        int r;
        case (sel)
            1:  r = a + b;
            2:  r = a - b;
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  r = ~a;
            7:  r = a;
            8:  r = b;
            9:  r = a * 2;
            10: r = a / 2;
            11: r = a + 1;
            12: r = a - 1;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Each accepted word executes to completion in program order; the pipeline must be indistinguishable.
    always @(negedge clk) begin
        logic        exp_stall;
        exp_t        e;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_alu_out", ALU_Out, 0);
            chk("rst_wb_data", wb_data, 0);
            expq.delete();
            m_ex_load = 1'b0;
            acc = 1'b0;
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
        end else begin
            exp_stall = m_ex_load && (m_ex_w == RF_A_addr || m_ex_w == RF_B_addr);
            chk("in_ready", in_ready, !exp_stall);
            if (!in_ready) stall_cnt++;
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                e = expq.pop_front();
                chk("out_valid", out_valid, 1);
                chk("ALU_A", ALU_A, e.a);
                chk("ALU_B", ALU_B, e.b);
                chk("ALU_Out", ALU_Out, e.alu);
                chk("wb_data", wb_data, e.wb);
                last_a = ALU_A; last_b = ALU_B; last_alu = ALU_Out; last_wb = wb_data;
            end else begin
                chk("out_valid_idle", out_valid, 0);
            end
            acc = in_valid && !exp_stall;
            m_ex_load = acc && RF_W_en && !RF_s;
            m_ex_w = RF_W_addr;
            if (acc) begin
                e.cyc = cyc + 2;
                e.a = m_regs[RF_A_addr];
                e.b = m_regs[RF_B_addr];
                e.alu = model_alu(int'(ALU_sel), int'(e.a), int'(e.b));
                if (D_wr) m_mem[D_addr] = e.a;
                e.wb = RF_s ? e.alu : m_mem[D_addr];
                if (RF_W_en) m_regs[RF_W_addr] = e.wb;
                expq.push_back(e);
            end
        end
    end

    task automatic issue(input logic [3:0] sel, input logic [3:0] w, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] d, input logic dwr, input logic rfs, input logic wen);
        int tries = 0;
        in_valid = 1'b1; ALU_sel = sel; RF_W_addr = w; RF_A_addr = a; RF_B_addr = b;
        D_addr = d; D_wr = dwr; RF_s = rfs; RF_W_en = wen;
        do begin
            @(posedge clk); #1;
            tries++;
        end while (!acc && tries < 4);
        chk("accept_bound", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic alu_op(input logic [3:0] sel, input logic [3:0] w, input logic [3:0] a, input logic [3:0] b);
        issue(sel, w, a, b, 8'h00, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic store(input logic [3:0] a, input logic [7:0] d);
        issue(ZERO, 4'd0, a, a, d, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic load(input logic [3:0] w, input logic [7:0] d);
        issue(ZERO, w, 4'd0, 4'd0, d, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic load_const(input logic [3:0] r, input logic [15:0] v);
        alu_op(ZERO, r, r, r);
        for (int i = 15; i >= 0; i--) begin
            alu_op(SHL, r, r, r);
            if (v[i]) alu_op(INC, r, r, r);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int r = 0; r < 16; r++) alu_op(ZERO, 4'(r), 4'(r), 4'(r));
        idle(3);
        chk("zero_last_alu", last_alu, 16'h0000);
        chk("zero_in_ready", in_ready, 1);

        for (int d = 0; d < 256; d++) store(4'd0, 8'(d));
        idle(3);

        load_const(4'd1, 16'd5);
        s0 = stall_cnt;
        alu_op(ADD, 4'd2, 4'd1, 4'd1);
        alu_op(ADD, 4'd3, 4'd2, 4'd1);
        idle(3);
        chk("fwd_alu_a", last_a, 16'd10);
        chk("fwd_alu_b", last_b, 16'd5);
        chk("fwd_alu_out", last_alu, 16'd15);
        chk("fwd_no_stall", stall_cnt - s0, 0);

        s0 = stall_cnt;
        store(4'd1, 8'h10);
        load(4'd4, 8'h10);
        alu_op(ADD, 4'd5, 4'd4, 4'd4);
        idle(3);
        chk("load_use_stall_cycles", stall_cnt - s0, 1);
        chk("load_use_alu_out", last_alu, 16'd10);

        load_const(4'd6, 16'hBEEF);
        store(4'd6, 8'hFF);
        load(4'd7, 8'hFF);
        idle(3);
        chk("load_ff", last_wb, 16'hBEEF);
        load(4'd8, 8'h00);
        idle(3);
        chk("load_00", last_wb, 16'h0000);

        load_const(4'd10, 16'h0001);
        alu_op(ZERO, 4'd0, 4'd0, 4'd0);
        alu_op(SUB, 4'd9, 4'd0, 4'd10);
        idle(3);
        chk("sub_wrap", last_alu, 16'hFFFF);
        load_const(4'd11, 16'h8001);
        alu_op(SHL, 4'd12, 4'd11, 4'd11);
        idle(3);
        chk("shl_8001", last_alu, 16'h0002);
        alu_op(4'd15, 4'd13, 4'd6, 4'd6);
        idle(3);
        chk("undef_opcode", last_alu, 16'h0000);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            else issue(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
                       8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        idle(3);

        load_const(4'd0, 16'h0000);
        store(4'd0, 8'h20);
        load_const(4'd6, 16'hBEEF);
        idle(3);
        alu_op(ADD, 4'd13, 4'd1, 4'd1);
        store(4'd6, 8'h20);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_alu_a", ALU_A, 0);
        chk("async_rst_alu_b", ALU_B, 0);
        chk("async_rst_alu_out", ALU_Out, 0);
        chk("async_rst_wb_data", wb_data, 0);
        chk("async_rst_in_ready", in_ready, 1);
        m_mem[8'h20] = 16'h0000;
        idle(3);
        rst_n = 1'b1;
        load(4'd2, 8'h20);
        idle(3);
        chk("store_discarded", last_wb, 16'h0000);
        alu_op(PASS_A, 4'd3, 4'd6, 4'd6);
        idle(3);
        chk("rf_cleared_a", last_a, 16'h0000);
        chk("rf_cleared_out", last_alu, 16'h0000);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
